// File: rtl/floating_to_fixed_conversion.sv
// IEEE-754 single -> unsigned Q10.22 magnitude converter, start/ready handshake, four-cycle FSM.
// Define FLOAT_TO_FIXED_ROUND_NEAREST_EN for round-to-nearest-even on right shifts (default: truncate).
module floating_to_fixed_conversion #(
  parameter int DATA_WIDTH = 32,
  parameter int M          = 23,
  parameter int E          = 8,
  parameter int INTEGER    = 10,
  parameter int FRACTION   = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_floating_to_fixed_conversion,
  input  logic [DATA_WIDTH-1:0] floating_point_input,
  output logic [DATA_WIDTH-1:0] fixed_point_output_reg,
  output logic                  sign_output_reg,
  output logic                  overflow_flag,
  output logic                  underflow_flag,
  output logic                  invalid_flag,
  output logic                  fixed_point_number_ready
);

  localparam int BIAS = (2**(E-1)) - 1;
  localparam int SIG_W = M + 1;
  localparam int LEFT_MAX = INTEGER + FRACTION - SIG_W;
  // Exponent at which the significand lands unshifted in the fixed word (128 for defaults).
  localparam logic [E-1:0] EXP_ONE = E'(BIAS + M - FRACTION);
  localparam logic [E-1:0] EXP_OVF = E'(BIAS + M - FRACTION + LEFT_MAX + 1);
  localparam logic [E-1:0] EXP_UNF = E'(BIAS + M - FRACTION - SIG_W);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    UNPACK       = 2'b01,
    SHIFT        = 2'b11,
    OUTPUT_READY = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    CLS_NORMAL, CLS_ZERO, CLS_DENORM, CLS_INF, CLS_NAN
  } class_t;

  state_t                state_q, state_d;
  class_t                class_q, class_d;
  logic [DATA_WIDTH-1:0] input_q, input_d;
  logic                  sign_q, sign_d;
  logic [E-1:0]          exp_q, exp_d;
  logic [SIG_W-1:0]      sig_q, sig_d;
  logic [DATA_WIDTH-1:0] fixed_q, fixed_d;
  logic                  sign_out_q, sign_out_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  inv_q, inv_d;
  logic                  ready_q, ready_d;

  logic [E-1:0]          left_amt, right_amt;
  logic [DATA_WIDTH-1:0] sig_ext, left_result, trunc_result, right_result;
  logic                  right_ovf;

  assign sig_ext      = {{(DATA_WIDTH-SIG_W){1'b0}}, sig_q};
  assign left_amt     = exp_q - EXP_ONE;
  assign right_amt    = EXP_ONE - exp_q;
  assign left_result  = sig_ext << left_amt;
  assign trunc_result = sig_ext >> right_amt;

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  logic [SIG_W-1:0]    guard_mask;
  logic                guard_bit, sticky_bit, round_up;
  logic [DATA_WIDTH:0] rounded_sum;

  // Guard is the highest dropped bit; sticky ORs everything below it.
  assign guard_mask  = {{M{1'b0}}, 1'b1} << (right_amt - E'(1));
  assign guard_bit   = |(sig_q & guard_mask);
  assign sticky_bit  = |(sig_q & (guard_mask - {{M{1'b0}}, 1'b1}));
  assign round_up    = guard_bit & (sticky_bit | trunc_result[0]);
  assign rounded_sum = {1'b0, trunc_result} + {{DATA_WIDTH{1'b0}}, round_up};
  assign right_ovf    = rounded_sum[DATA_WIDTH];
  assign right_result = right_ovf ? ALL_ONES : rounded_sum[DATA_WIDTH-1:0];
`else
  assign right_ovf    = 1'b0;
  assign right_result = trunc_result;
`endif

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    input_d    = input_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sig_d      = sig_q;
    fixed_d    = fixed_q;
    sign_out_d = sign_out_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inv_d      = inv_q;
    ready_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_floating_to_fixed_conversion) begin
          input_d = floating_point_input;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d = input_q[DATA_WIDTH-1];
        exp_d  = input_q[M +: E];
        sig_d  = {1'b1, input_q[M-1:0]};
        if (input_q[M +: E] == '0)
          class_d = (input_q[M-1:0] == '0) ? CLS_ZERO : CLS_DENORM;
        else if (input_q[M +: E] == '1)
          class_d = (input_q[M-1:0] == '0) ? CLS_INF : CLS_NAN;
        else
          class_d = CLS_NORMAL;
        state_d = SHIFT;
      end
      SHIFT: begin
        fixed_d    = '0;
        sign_out_d = sign_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        inv_d      = 1'b0;
        case (class_q)
          CLS_ZERO:   ;
          CLS_DENORM: unf_d = 1'b1;
          CLS_INF: begin
            fixed_d = ALL_ONES;
            ovf_d   = 1'b1;
          end
          CLS_NAN: begin
            sign_out_d = 1'b0;
            inv_d      = 1'b1;
          end
          default: begin
            if (exp_q >= EXP_OVF) begin
              fixed_d = ALL_ONES;
              ovf_d   = 1'b1;
            end else if (exp_q >= EXP_ONE) begin
              fixed_d = left_result;
            end else if (exp_q >= EXP_UNF) begin
              fixed_d = right_result;
              ovf_d   = right_ovf;
              unf_d   = (right_result == '0);
            end else begin
              unf_d = 1'b1;
            end
          end
        endcase
        state_d = OUTPUT_READY;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      class_q    <= CLS_NORMAL;
      input_q    <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sig_q      <= '0;
      fixed_q    <= '0;
      sign_out_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inv_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      input_q    <= input_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sig_q      <= sig_d;
      fixed_q    <= fixed_d;
      sign_out_q <= sign_out_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inv_q      <= inv_d;
      ready_q    <= ready_d;
    end
  end

  assign fixed_point_output_reg   = fixed_q;
  assign sign_output_reg          = sign_out_q;
  assign overflow_flag            = ovf_q;
  assign underflow_flag           = unf_q;
  assign invalid_flag             = inv_q;
  assign fixed_point_number_ready = ready_q;

endmodule

// File: tb/tb_floating_to_fixed_conversion.sv
// Directed scoreboard bench for floating_to_fixed_conversion; flags packed as {sign, ovf, unf, inv}.
module tb_floating_to_fixed_conversion;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] fp_in;
  logic [31:0] fixed_out;
  logic        sign_out, ovf, unf, inv, ready;

  floating_to_fixed_conversion dut (
    .clk                                (clk),
    .reset                              (reset),
    .start_floating_to_fixed_conversion (start),
    .floating_point_input               (fp_in),
    .fixed_point_output_reg             (fixed_out),
    .sign_output_reg                    (sign_out),
    .overflow_flag                      (ovf),
    .underflow_flag                     (unf),
    .invalid_flag                       (inv),
    .fixed_point_number_ready           (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] fixed;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_total = checks_total + 1;
    assert (obs === expv) checks_passed = checks_passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_entries"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " fixed"}, fixed_out, e.fixed);
      check({tag, " flags"}, {28'b0, sign_out, ovf, unf, inv}, {28'b0, e.flags});
    end
  endtask

  // One full handshake: start for one edge, then scramble the input to prove it was captured.
  task automatic do_conv(input logic [31:0] fp, input logic [31:0] ef, input logic [3:0] eflags);
    int    lat;
    string tag;
    tag = $sformatf("in=%h", fp);
    @(negedge clk);
    fp_in = fp;
    start = 1'b1;
    sb.push_back('{fixed: ef, flags: eflags});
    @(posedge clk); #1;
    start = 1'b0;
    fp_in = $urandom;
    lat = 0;
    while (!ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check_result(tag);
    @(posedge clk); #1;
    check({tag, " ready_width"}, {31'b0, ready}, 32'd0);
    $display("conv %s -> out=%h sign=%b ovf=%b unf=%b inv=%b", fp, fixed_out, sign_out, ovf, unf, inv);
  endtask

  logic [31:0] vals [12];
  logic [31:0] lsb15_exp;
  int          readies;

  initial begin
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
    lsb15_exp = 32'h0000_0002;
`else
    lsb15_exp = 32'h0000_0001;
`endif
    reset = 1'b1;
    start = 1'b0;
    fp_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset fixed", fixed_out, 32'h0);
    check("reset flags_ready", {27'b0, sign_out, ovf, unf, inv, ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_conv(32'h3F80_0000, 32'h0040_0000, 4'b0000);  // 1.0
    do_conv(32'hC060_0000, 32'h00E0_0000, 4'b1000);  // -3.5
    do_conv(32'h34C0_0000, lsb15_exp,      4'b0000);  // 1.5 LSB
    do_conv(32'h3520_0000, 32'h0000_0002, 4'b0000);  // 2.5 LSB, tie to even
    do_conv(32'h4480_0000, 32'hFFFF_FFFF, 4'b0100);  // 1024.0
    do_conv(32'h447F_FFFF, 32'hFFFF_FF00, 4'b0000);  // largest value below 1024
    do_conv(32'h7F80_0000, 32'hFFFF_FFFF, 4'b0100);  // +inf
    do_conv(32'hFF80_0000, 32'hFFFF_FFFF, 4'b1100);  // -inf
    do_conv(32'h7FC0_0000, 32'h0000_0000, 4'b0001);  // NaN
    do_conv(32'hFFC0_0000, 32'h0000_0000, 4'b0001);  // negative NaN, sign forced 0
    do_conv(32'h0000_0001, 32'h0000_0000, 4'b0010);  // denormal
    do_conv(32'h8000_0000, 32'h0000_0000, 4'b1000);  // -0
    do_conv(32'h0080_0000, 32'h0000_0000, 4'b0010);  // smallest normal
    do_conv(32'h3400_0000, 32'h0000_0000, 4'b0010);  // half LSB, shifted out
    do_conv(32'h3DCC_CCCD, 32'h0006_6666, 4'b0000);  // 0.1

    // Start held high: only inputs present at IDLE edges (k = 0, 4, 8) are converted.
    vals = '{32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0001,
             32'h4000_0000, 32'h4480_0000, 32'h7F80_0000, 32'h7FC0_0000,
             32'h3DCC_CCCD, 32'h7FC0_0000, 32'h0000_0001, 32'h4480_0000};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = 1'b1;
      fp_in = vals[k];
      if (k % 4 == 0) begin
        case (k)
          0:       sb.push_back('{fixed: 32'h0040_0000, flags: 4'b0000});
          4:       sb.push_back('{fixed: 32'h0080_0000, flags: 4'b0000});
          default: sb.push_back('{fixed: 32'h0006_6666, flags: 4'b0000});
        endcase
      end
      @(posedge clk); #1;
      check($sformatf("stream cycle%0d ready", k), {31'b0, ready}, {31'b0, (k % 4 == 3)});
      if (ready) begin
        check_result($sformatf("stream cycle%0d", k));
        $display("stream cycle %0d -> out=%h flags=%b", k, fixed_out, {sign_out, ovf, unf, inv});
      end
    end
    start = 1'b0;

    // Leave nonzero outputs, then reset while the next conversion is in SHIFT.
    do_conv(32'hC060_0000, 32'h00E0_0000, 4'b1000);
    @(negedge clk);
    fp_in = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort fixed", fixed_out, 32'h0);
    check("abort flags_ready", {27'b0, sign_out, ovf, unf, inv, ready}, 32'h0);
    readies = 0;
    repeat (2) begin
      @(posedge clk); #1;
      readies += int'(ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      readies += int'(ready);
    end
    check("abort ready_pulses", 32'(readies), 32'd0);
    $display("abort -> ready pulses=%0d", readies);
    do_conv(32'h4000_0000, 32'h0080_0000, 4'b0000);  // 2.0

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
